// File: rtl/gps_pkg.sv
// Shared GPS definitions: UART receiver state encoding, baud divider helper
// and the NMEA framing characters used by the sentence parser.
package gps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK
  } uart_state_t;

  localparam logic [7:0] NMEA_DOLLAR = 8'h24;
  localparam logic [7:0] NMEA_COMMA  = 8'h2C;
  localparam logic [7:0] NMEA_STAR   = 8'h2A;
  localparam logic [7:0] NMEA_CR     = 8'h0D;
  localparam logic [7:0] NMEA_LF     = 8'h0A;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable by clr
// so the sample phase can be aligned to a start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/gps_uart_rx.sv
// 8N1 UART receiver for the GPS NMEA stream: 2-FF sync, 16x oversampling,
// 2-of-3 majority vote per bit, one-clk valid / framing-error strobes.
module gps_uart_rx
  import gps_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned M   = OVERSAMPLE / 2;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_PRE  = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_POST = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  uart_state_t   state, state_nxt;
  logic          rx_m, rx_s;
  logic [1:0]    settle;
  logic          armed;
  logic          tick, clr, bit_end, vote;
  logic          shift_en, load, ferr;
  logic [SW-1:0] scnt;
  logic [2:0]    smp;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  // armed means rx_s has genuinely been seen high since the last start; it
  // replaces a plain delayed-rx edge detector so a start edge that coincides
  // with the stop-bit end is still taken in IDLE one clk later, and the
  // reset value of the sync flops never counts as a high level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      settle <= {settle[0], 1'b1};
      if (clr) begin
        armed <= 1'b0;
      end else if (rx_s && settle[1]) begin
        armed <= 1'b1;
      end
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign bit_end = tick && (scnt == S_LAST);
  assign vote    = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    ferr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !rx_s) begin
          clr       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick && scnt == S_MID && rx_s) begin
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          state_nxt = vote ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (idx == 3'd7) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (vote) begin
            load      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = ST_BRK;
          end
        end
      end
      ST_BRK: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt      <= '0;
      smp       <= '1;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load;
      frame_err <= ferr;
      if (clr) begin
        scnt <= '0;
        idx  <= '0;
      end else if (tick) begin
        scnt <= (scnt == S_LAST) ? '0 : scnt + SW'(1);
      end
      if (tick) begin
        if (scnt == S_PRE)  smp[0] <= rx_s;
        if (scnt == S_MID)  smp[1] <= rx_s;
        if (scnt == S_POST) smp[2] <= rx_s;
      end
      if (shift_en) begin
        shreg <= {vote, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
      if (load) begin
        rx_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_gps_uart_rx.sv
// Directed bench for gps_uart_rx at a reduced clock/baud ratio (160 clk/bit).
module tb_gps_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  always #5 clk = ~clk;

  gps_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid = 0, n_ferr = 0, n_busy_rise = 0, n_both = 0, n_valid_busy = 0;
  logic busy_q = 1'b0;
  logic [7:0] rx_log[$];

  // Strobe monitor: records every received byte and strobe anomalies.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      rx_log.push_back(rx_data);
      if (busy) n_valid_busy <= n_valid_busy + 1;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_valid && frame_err) n_both <= n_both + 1;
    if (busy && !busy_q) n_busy_rise <= n_busy_rise + 1;
    busy_q <= busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_slot(input logic v, input int unsigned len, input bit spike);
    rx = v;
    if (spike) begin
      wait_clk(len / 2);
      rx = ~v;
      wait_clk(1);
      rx = v;
      wait_clk(len - len / 2 - 1);
    end else begin
      wait_clk(len);
    end
  endtask

  // Slot 0 is the start bit, slots 1..8 the data LSB first, slot 9 the stop bit.
  task automatic send_bits(input logic [7:0] data, input logic stop,
                           input int unsigned nslots, input int unsigned len, input bit spike);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    for (int unsigned i = 0; i < nslots; i++) begin
      drive_slot(fr[i], len, spike);
    end
  endtask

  logic [7:0] msg [7] = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C};
  int br;

  initial begin
    // Reset with rx held low
    rst = 1'b0;
    rx  = 1'b0;
    wait_clk(5);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    wait_clk(3 * BIT);
    check("low_from_reset_no_start", n_busy_rise, 0);
    check("low_from_reset_busy", busy, 1'b0);
    rx = 1'b1;
    wait_clk(2 * BIT);

    // 1. single '$'
    send_bits(8'h24, 1'b1, 10, BIT, 1'b0);
    wait_clk(BIT);
    check("t1_count", n_valid, 1);
    check("t1_data", rx_log[0], 8'h24);
    check("t1_rx_data", rx_data, 8'h24);
    check("t1_no_ferr", n_ferr, 0);
    check("t1_busy_idle", busy, 1'b0);

    // 2. back-to-back "$GPRMC,"
    for (int i = 0; i < 7; i++) begin
      send_bits(msg[i], 1'b1, 10, BIT, 1'b0);
    end
    wait_clk(2 * BIT);
    check("t2_count", n_valid, 8);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t2_byte%0d", i), rx_log[1 + i], msg[i]);
    end

    // 3. 0.3-bit glitch
    br = n_busy_rise;
    rx = 1'b0;
    wait_clk(BIT * 3 / 10);
    rx = 1'b1;
    wait_clk(2 * BIT);
    check("t3_busy_pulse", n_busy_rise, br + 1);
    check("t3_no_valid", n_valid, 8);
    check("t3_no_ferr", n_ferr, 0);
    check("t3_idle", busy, 1'b0);

    // 4. framing error then held break
    send_bits(8'h55, 1'b0, 10, BIT, 1'b0);
    rx = 1'b0;
    wait_clk(20 * BIT);
    check("t4_ferr_once", n_ferr, 1);
    check("t4_data_kept", rx_data, 8'h2C);
    check("t4_no_valid", n_valid, 8);
    check("t4_busy_in_break", busy, 1'b1);
    rx = 1'b1;
    wait_clk(2 * BIT);
    check("t4_break_released", busy, 1'b0);
    send_bits(8'hAA, 1'b1, 10, BIT, 1'b0);
    wait_clk(BIT);
    check("t4_next_count", n_valid, 9);
    check("t4_next_data", rx_log[8], 8'hAA);
    check("t4_ferr_still_once", n_ferr, 1);

    // 5. spikes at bit centres with +/-2% baud error
    send_bits(8'hA5, 1'b1, 10, BIT + 3, 1'b1);
    wait_clk(2 * BIT);
    check("t5_slow_data", rx_log[9], 8'hA5);
    send_bits(8'hA5, 1'b1, 10, BIT - 3, 1'b1);
    wait_clk(2 * BIT);
    check("t5_fast_data", rx_log[10], 8'hA5);
    check("t5_count", n_valid, 11);
    check("t5_no_ferr", n_ferr, 1);

    // 6. reset during data bit 4
    send_bits(8'h3C, 1'b1, 5, BIT, 1'b0);
    rx = 1'b1;
    wait_clk(BIT / 2);
    rst = 1'b0;
    wait_clk(3);
    check("t6_reset_data", rx_data, 8'h00);
    check("t6_reset_busy", busy, 1'b0);
    check("t6_reset_valid", rx_valid, 1'b0);
    rst = 1'b1;
    wait_clk(12 * BIT);
    check("t6_no_abort_strobe", n_valid, 11);
    check("t6_idle", busy, 1'b0);
    send_bits(8'h0D, 1'b1, 10, BIT, 1'b0);
    wait_clk(BIT);
    check("t6_count", n_valid, 12);
    check("t6_data", rx_data, 8'h0D);
    check("t6_no_ferr", n_ferr, 1);

    check("never_both_strobes", n_both, 0);
    check("busy_low_at_valid", n_valid_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
